// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Groups the instruction fetch unit's bus signals: the instruction memory
//   req/ack read port, the branch redirect from execute, the downstream stall,
//   and the instruction presented to decode.
//
//   master : the fetch unit (drives imem_req/imem_addr and the decode outputs)
//   slave  : the surrounding system (memory, execute stage, decode stage)
//
//   imem_req      read request to instruction memory
//   imem_addr     read address, valid while imem_req=1
//   imem_ack      memory returns imem_rdata this cycle
//   imem_rdata    instruction word, sampled only when imem_ack=1
//   branch_taken  one-cycle redirect pulse
//   branch_target redirect address (bits [1:0] ignored)
//   stall         downstream cannot accept the presented instruction
//   instr_valid   instr/opcode/pc_out hold a live instruction
//   instr         fetched instruction word
//   opcode        instr[6:0]
//   pc_out        address instr was fetched from
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
) ();
    logic                 imem_req;
    logic [ADDR_W-1:0]    imem_addr;
    logic                 imem_ack;
    logic [INSTR_W-1:0]   imem_rdata;
    logic                 branch_taken;
    logic [ADDR_W-1:0]    branch_target;
    logic                 stall;
    logic                 instr_valid;
    logic [INSTR_W-1:0]   instr;
    logic [6:0]           opcode;
    logic [ADDR_W-1:0]    pc_out;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
        input  imem_ack, imem_rdata, branch_taken, branch_target, stall
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
        output imem_ack, imem_rdata, branch_taken, branch_target, stall
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Holds the program counter, issues single-outstanding reads to instruction
//   memory, and presents each fetched word (with its opcode field and fetch
//   address) to decode. Branch redirects from execute retarget the PC; a
//   redirect that arrives while a read is in flight is remembered until that
//   read completes, and the returned word is then dropped.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - instr_fetch_unit_if.master (memory port, redirect, stall, outputs)
//
//   Two states: FETCH (request outstanding) and DELIVER (instruction presented,
//   held while stall=1).
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned        ADDR_W   = 64,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_unit_if.master    bus
);

    typedef enum logic [0:0] {
        ST_FETCH   = 1'b0,
        ST_DELIVER = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'd4};
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Clears the byte-offset bits of a redirect address.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 redirect_pend_q, redirect_pend_d;
    logic [ADDR_W-1:0]    redirect_tgt_q, redirect_tgt_d;
    logic                 instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    pc_out_q, pc_out_d;

    // Request is gated by rst so no read is issued during reset cycles.
    assign bus.imem_req    = (state_q == ST_FETCH) && !rst;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[6:0];
    assign bus.pc_out      = pc_out_q;

    // Next-state logic for the fetch sequencer and the presented instruction.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        redirect_pend_d = redirect_pend_q;
        redirect_tgt_d  = redirect_tgt_q;
        instr_valid_d   = instr_valid_q;
        instr_d         = instr_q;
        pc_out_d        = pc_out_q;

        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    if (bus.branch_taken) begin
                        // Completed read is stale: restart at the new target.
                        pc_d            = word_align(bus.branch_target);
                        redirect_pend_d = 1'b0;
                    end else if (redirect_pend_q) begin
                        pc_d            = redirect_tgt_q;
                        redirect_pend_d = 1'b0;
                    end else begin
                        instr_d       = bus.imem_rdata;
                        pc_out_d      = pc_q;
                        pc_d          = pc_q + PC_STEP;
                        instr_valid_d = 1'b1;
                        state_d       = ST_DELIVER;
                    end
                end else if (bus.branch_taken) begin
                    // Address must stay stable until the ack, so park the target.
                    redirect_tgt_d  = word_align(bus.branch_target);
                    redirect_pend_d = 1'b1;
                end else begin
                    redirect_pend_d = redirect_pend_q;
                end
            end
            ST_DELIVER: begin
                if (bus.branch_taken) begin
                    pc_d          = word_align(bus.branch_target);
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end else if (bus.stall) begin
                    state_d = ST_DELIVER;
                end else begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end
            end
            default: begin
                state_d       = ST_FETCH;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_FETCH;
            pc_q            <= RESET_PC;
            redirect_pend_q <= 1'b0;
            redirect_tgt_q  <= {ADDR_W{1'b0}};
            instr_valid_q   <= 1'b0;
            instr_q         <= {INSTR_W{1'b0}};
            pc_out_q        <= {ADDR_W{1'b0}};
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            redirect_pend_q <= redirect_pend_d;
            redirect_tgt_q  <= redirect_tgt_d;
            instr_valid_q   <= instr_valid_d;
            instr_q         <= instr_d;
            pc_out_q        <= pc_out_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch unit: holds the program counter, issues single-outstanding reads to instruction memory over a req/ack handshake, and presents the fetched word and its opcode field to the main control decoder and datapath.
- Accepts branch redirects from the execute stage.
- Accepts a stall from downstream that freezes the presented instruction.
- Sits between instruction memory and the control/decode stage.

Parameters:
ADDR_W, 64, width of PC and instruction memory address
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  read request to instruction memory
imem_addr  output  ADDR_W  read address; valid while imem_req=1
imem_ack  input  1  memory has returned imem_rdata this cycle
imem_rdata  input  INSTR_W  instruction word; sampled only when imem_ack=1
branch_taken  input  1  one-cycle pulse: redirect fetch to branch_target
branch_target  input  ADDR_W  redirect address; bits [1:0] ignored
stall  input  1  downstream cannot accept the presented instruction
instr_valid  output  1  instr/opcode/pc_out hold a live instruction
instr  output  INSTR_W  fetched instruction word
opcode  output  7  instr[6:0], the control decoder input
pc_out  output  ADDR_W  address instr was fetched from

Behaviour:
- Reset (rst=1 at an edge) takes effect on that edge and abandons any operation in progress:
  - state=FETCH, pc=RESET_PC, redirect_pend=0.
  - instr_valid=0, instr=0, pc_out=0.
  - imem_req forced to 0 while rst=1.
  - The instruction memory is reset by the same rst; acks for pre-reset requests never arrive.
- Outputs:
  - opcode is instr[6:0], combinational from the instr register.
  - imem_req = (state==FETCH) && !rst.
  - imem_addr = pc.
- Handshake: once imem_req rises, imem_addr stays stable and imem_req stays high until the cycle imem_ack=1. The ack may arrive in the same cycle as req. imem_ack outside FETCH is ignored.
- FETCH state:
  - imem_ack=1, redirect_pend=0, branch_taken=0:
    - instr<=imem_rdata, pc_out<=pc, pc<=pc+4, instr_valid<=1, state<=DELIVER.
    - Latency: ack in cycle N gives instr_valid=1 in cycle N+1.
  - imem_ack=1 and (redirect_pend=1 or branch_taken=1):
    - Discard rdata.
    - pc<=target with [1:0]=0. Target is branch_target if branch_taken, else the saved target.
    - redirect_pend<=0; stay in FETCH.
    - The new request is presented the next cycle.
  - imem_ack=0, branch_taken=1:
    - Save branch_target (masked) and set redirect_pend<=1.
    - pc is unchanged; the request in flight completes and is discarded.
    - A later branch_taken overwrites the saved target.
- DELIVER state:
  - branch_taken=1: pc<=target (masked), instr_valid<=0, state<=FETCH. Branch has priority over stall.
  - Else stall=1: hold all outputs and pc unchanged, with no limit on stall length.
  - Else: instr_valid<=0, state<=FETCH.
  - Peak throughput is one instruction per 2 cycles, with zero-wait memory.
- Arithmetic: pc+4 is modulo 2^ADDR_W. From pc = all ones minus 3 it wraps to 0 with no error.
- branch_taken asserted during rst is ignored.
- stall in FETCH has no effect.

Test Plan:
1. Reset and zero-wait fetch:
   - Stimulus: rst high 2 cycles then low; memory acks in the same cycle as req, rdata=0x00000033 at addr 0, 0x00002003 at addr 4.
   - Required: first req at addr 0 the cycle after rst falls. instr_valid pulses with opcode=0x33, pc_out=0, then opcode=0x03, pc_out=4. imem_addr sequence is 0, 4, 8.
2. Wait states and stall:
   - Stimulus: ack delayed 3 cycles; stall held 4 cycles while instr_valid=1.
   - Required: imem_req and imem_addr stable through the wait. instr, opcode and pc_out unchanged during the stall. The next req at pc+4 comes only after stall drops.
3. Branch in DELIVER with stall=1:
   - Stimulus: branch_taken=1, branch_target=0x107.
   - Required: instr_valid=0 the next cycle; the next req address is 0x104.
4. Branch while a request is in flight:
   - Stimulus: req at addr 0x20, no ack; branch_taken pulses with target 0x80; ack arrives 2 cycles later with rdata=0x00000063.
   - Required: data discarded and no instr_valid. The next req is at 0x80, and the delivered pc_out is 0x80.
5. Branch coincident with ack:
   - Stimulus: branch_taken and imem_ack in the same FETCH cycle, target 0x40.
   - Required: rdata dropped; the next req is at 0x40.
6. Reset mid-stall and wrap-around:
   - Stimulus: rst pulses during DELIVER with stall=1.
   - Required: instr_valid=0 and pc=RESET_PC on that edge.
   - Stimulus: separately, branch to 0xFFFFFFFFFFFFFFFC and complete the fetch.
   - Required: the next imem_addr is 0.
